// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, field widths, colours and arbiter state shared by the plot path
package vga_pkg;
    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;
    localparam int X_W           = 8;
    localparam int Y_W           = 7;
    localparam int COLOUR_W      = 3;
    localparam logic [COLOUR_W-1:0] BLACK  = 3'b000;
    localparam logic [COLOUR_W-1:0] BLUE   = 3'b001;
    localparam logic [COLOUR_W-1:0] GREEN  = 3'b010;
    localparam logic [COLOUR_W-1:0] YELLOW = 3'b110;
    localparam logic [COLOUR_W-1:0] RED    = 3'b100;
    localparam logic [COLOUR_W-1:0] WHITE  = 3'b111;
    typedef enum logic {CLEAR, SERVE} state_t;
endpackage

// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if: engine request bundle plus adapter pixel port; slave is the arbiter side
interface plot_arbiter_if import vga_pkg::*; #(parameter int N_REQ = 5) ();
    logic                      clear_start;
    logic [N_REQ-1:0]          req;
    logic [X_W*N_REQ-1:0]      req_x;
    logic [Y_W*N_REQ-1:0]      req_y;
    logic [COLOUR_W*N_REQ-1:0] req_colour;
    logic [N_REQ-1:0]          grant;
    logic [X_W-1:0]            x;
    logic [Y_W-1:0]            y;
    logic [COLOUR_W-1:0]       colour;
    logic                      plot;
    logic                      clearing;
    logic                      idle;
    modport master (
        output clear_start, req, req_x, req_y, req_colour,
        input  grant, x, y, colour, plot, clearing, idle
    );
    modport slave (
        input  clear_start, req, req_x, req_y, req_colour,
        output grant, x, y, colour, plot, clearing, idle
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, priority starts at ptr_i and wraps mod N
module rr_pick #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);
    function automatic int wrap(input int a);
        return (a >= N) ? a - N : a;
    endfunction
    // scan from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[wrap(int'(ptr_i) + k)]) begin
                idx_o = PW'(wrap(int'(ptr_i) + k));
                any_o = 1'b1;
            end
        end
        grant_o = '0;
        grant_o[idx_o] = any_o;
    end
endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: owns the adapter pixel port, sweeps a clear colour then serves engines round-robin
module plot_arbiter import vga_pkg::*; #(
    parameter int                  N_REQ          = 5,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR   = BLACK,
    parameter bit                  CLEAR_ON_RESET = 1'b1
) (
    input logic           CLOCK_50,
    input logic           reset,
    plot_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    state_t              state_q, state_d;
    logic [X_W-1:0]      cx_q, cx_d, x_q, x_d, px;
    logic [Y_W-1:0]      cy_q, cy_d, y_q, y_d, py;
    logic [COLOUR_W-1:0] colour_q, colour_d, pc;
    logic [PW-1:0]       ptr_q, ptr_d, pick_idx;
    logic [N_REQ-1:0]    pick_grant;
    logic                plot_q, plot_d, clearing_q, clearing_d, idle_q, idle_d;
    logic                pick_any, take, wrap_x, sweep_end;
    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req_i  (bus.req),
        .ptr_i  (ptr_q),
        .grant_o(pick_grant),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );
    assign wrap_x    = cx_q == X_W'(SCREEN_WIDTH - 1);
    assign sweep_end = wrap_x && cy_q == Y_W'(SCREEN_HEIGHT - 1);
    // a clear request or reset voids any grant in the same cycle so the request stays pending
    assign take      = state_q == SERVE && !reset && !bus.clear_start && pick_any;
    assign px        = bus.req_x[X_W*int'(pick_idx) +: X_W];
    assign py        = bus.req_y[Y_W*int'(pick_idx) +: Y_W];
    assign pc        = bus.req_colour[COLOUR_W*int'(pick_idx) +: COLOUR_W];
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= CLEAR_ON_RESET ? CLEAR : SERVE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = bus.clear_start ? CLEAR : (state_q == CLEAR && sweep_end) ? SERVE : state_q;
    end
    always_comb begin
        cx_d       = bus.clear_start ? '0 : (state_q == CLEAR) ? (wrap_x ? '0 : cx_q + 1'b1) : cx_q;
        cy_d       = bus.clear_start ? '0 : (state_q == CLEAR && wrap_x) ?
                     (sweep_end ? '0 : cy_q + 1'b1) : cy_q;
        x_d        = (state_q == CLEAR) ? cx_q : take ? px : x_q;
        y_d        = (state_q == CLEAR) ? cy_q : take ? py : y_q;
        colour_d   = (state_q == CLEAR) ? CLEAR_COLOUR : take ? pc : colour_q;
        plot_d     = !bus.clear_start && (state_q == CLEAR ||
                     (take && px < X_W'(SCREEN_WIDTH) && py < Y_W'(SCREEN_HEIGHT)));
        ptr_d      = take ? ((int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1) : ptr_q;
        clearing_d = state_d == CLEAR;
        idle_d     = state_d == SERVE && !(|bus.req);
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cx_q       <= '0;
            cy_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            ptr_q      <= '0;
            clearing_q <= CLEAR_ON_RESET;
            idle_q     <= 1'b0;
        end else begin
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            ptr_q      <= ptr_d;
            clearing_q <= clearing_d;
            idle_q     <= idle_d;
        end
    end
    assign bus.grant    = take ? pick_grant : '0;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.colour   = colour_q;
    assign bus.plot     = plot_q;
    assign bus.clearing = clearing_q;
    assign bus.idle     = idle_q;
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed stimulus with a pixel scoreboard checked by an output monitor
module tb_plot_arbiter;
    import vga_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int n;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;
    always #5 clk = ~clk;
    plot_arbiter_if #(.N_REQ(5)) bus ();
    plot_arbiter #(.N_REQ(5), .CLEAR_COLOUR(BLACK), .CLEAR_ON_RESET(1'b1)) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask
    task automatic push(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        exp_q.push_back({x, y, c});
    endtask
    task automatic push_clear();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                push(8'(xx), 7'(yy), BLACK);
    endtask
    task automatic set_eng(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bus.req[i] = 1'b1;
        bus.req_x[8*i +: 8] = x;
        bus.req_y[7*i +: 7] = y;
        bus.req_colour[3*i +: 3] = c;
    endtask
    task automatic wait_sweep(input string name);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.clearing && n < 20000);
        chk(name, n, 19200);
    endtask
    always @(negedge clk) begin
        if (bus.plot === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel: unexpected plot got (%0d,%0d,%0d) expected none",
                         bus.x, bus.y, bus.colour);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.x, bus.y, bus.colour} !== mon_e) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             bus.x, bus.y, bus.colour, mon_e[17:10], mon_e[9:3], mon_e[2:0]);
                end
            end
        end
    end
    initial begin
        rst = 1'b1;
        bus.clear_start = 1'b0;
        bus.req = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_colour = '0;
        repeat (3) tick();
        chk("reset_plot", int'(bus.plot), 0);
        chk("reset_clearing", int'(bus.clearing), 1);
        chk("reset_idle", int'(bus.idle), 0);
        chk("reset_x", int'(bus.x), 0);
        chk("reset_grant", int'(bus.grant), 0);
        // power-up sweep
        rst = 1'b0;
        push_clear();
        wait_sweep("sweep_len");
        chk("sweep_idle", int'(bus.idle), 1);
        chk("sweep_last_plot", int'(bus.plot), 1);
        // single engine, back-to-back pixels
        set_eng(2, 8'd40, 7'd40, 3'd1);
        #1 chk("e2_grant_a", int'(bus.grant), 4);
        push(8'd40, 7'd40, 3'd1);
        tick();
        set_eng(2, 8'd41, 7'd40, 3'd1);
        #1 chk("e2_grant_b", int'(bus.grant), 4);
        push(8'd41, 7'd40, 3'd1);
        tick();
        bus.req = '0;
        set_eng(4, 8'd100, 7'd50, 3'd2);
        #1 chk("e4_grant", int'(bus.grant), 16);
        push(8'd100, 7'd50, 3'd2);
        tick();
        bus.req = '0;
        // all engines, pointer now 0
        for (int i = 0; i < 5; i++) set_eng(i, 8'(10 * i), 7'(i), 3'(i));
        for (int k = 0; k < 10; k++) begin
            #1 chk("rr_grant", int'(bus.grant), 1 << (k % 5));
            push(8'(10 * (k % 5)), 7'(k % 5), 3'(k % 5));
            tick();
        end
        bus.req = '0;
        // out-of-range pixel consumed without a plot
        set_eng(1, 8'd160, 7'd10, 3'd4);
        #1 chk("oor_grant", int'(bus.grant), 2);
        tick();
        chk("oor_plot", int'(bus.plot), 0);
        set_eng(1, 8'd159, 7'd119, 3'd4);
        #1 chk("edge_grant", int'(bus.grant), 2);
        push(8'd159, 7'd119, 3'd4);
        tick();
        bus.req = '0;
        set_eng(3, 8'd5, 7'd5, 3'd7);
        #1 chk("e3_grant", int'(bus.grant), 8);
        push(8'd5, 7'd5, 3'd7);
        tick();
        bus.req = '0;
        // clear_start with pending requests, pointer now 4
        set_eng(0, 8'd1, 7'd2, 3'd3);
        set_eng(3, 8'd4, 7'd5, 3'd6);
        bus.clear_start = 1'b1;
        #1 chk("cs_grant", int'(bus.grant), 0);
        push_clear();
        n = 0;
        do begin
            tick();
            bus.clear_start = 1'b0;
            n++;
            #1;
            if (n == 1) chk("cs_clearing", int'(bus.clearing), 1);
        end while (bus.grant == 0 && n < 20000);
        chk("cs_len", n, 19201);
        chk("cs_first_grant", int'(bus.grant), 1);
        push(8'd1, 7'd2, 3'd3);
        tick();
        bus.req[0] = 1'b0;
        #1 chk("cs_second_grant", int'(bus.grant), 8);
        push(8'd4, 7'd5, 3'd6);
        tick();
        bus.req = '0;
        // reset in SERVE voids the grant, then reset again mid-sweep
        set_eng(2, 8'd7, 7'd7, 3'd1);
        rst = 1'b1;
        #1 chk("rst_grant", int'(bus.grant), 0);
        tick();
        bus.req = '0;
        tick();
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_clearing", int'(bus.clearing), 1);
        rst = 1'b0;
        push_clear();
        repeat (500) tick();
        chk("mid_plot", int'(bus.plot), 1);
        rst = 1'b1;
        exp_q.delete();
        push_clear();
        tick();
        tick();
        chk("mid_rst_plot", int'(bus.plot), 0);
        chk("mid_rst_x", int'(bus.x), 0);
        rst = 1'b0;
        wait_sweep("resweep_len");
        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
Controller that owns the single pixel-write port (x, y, colour, plot) of the 160x120 VGA adapter and shares it among N independent shape-drawing engines (circle/fill state machines).
After reset, and on request, it sweeps the whole frame to a clear colour. After that it serves engine pixel requests round-robin, one pixel per clock.
It replaces the ad-hoc "turn" multiplexer between drawing engines and the adapter.

Parameters:
N_REQ, 5, number of drawing engines (1..8)
CLEAR_COLOUR, 3'b000, colour written during a clear sweep
CLEAR_ON_RESET, 1, 1 = start a clear sweep on leaving reset; 0 = go straight to SERVE

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
clear_start  in  1  one-cycle pulse: (re)start a full-frame clear sweep
req  in  N_REQ  per-engine pixel request; held until granted
req_x  in  8*N_REQ  engine i x in bits [8i+7:8i]
req_y  in  7*N_REQ  engine i y in bits [7i+6:7i]
req_colour  in  3*N_REQ  engine i colour in bits [3i+2:3i]
grant  out  N_REQ  one-hot, combinational; engine i pixel consumed at this edge
x  out  8  to adapter, registered
y  out  7  to adapter, registered
colour  out  3  to adapter, registered
plot  out  1  to adapter, registered write enable
clearing  out  1  registered; high while in CLEAR
idle  out  1  registered; high in SERVE with no req asserted

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous, active-high.
- Reset values:
  - x=0, y=0, colour=0, plot=0, idle=0.
  - clearing=CLEAR_ON_RESET.
  - rr pointer=0.
  - Sweep counters cx=0, cy=0.
  - State = CLEAR if CLEAR_ON_RESET, else SERVE.
  - grant=0 while reset is high.
- States: CLEAR, SERVE. Two states only; no other states.
- CLEAR:
  - Each cycle, register x=cx, y=cy, colour=CLEAR_COLOUR, plot=1.
  - cx increments 0..159, then wraps to 0 and cy increments; y order is 0..119.
  - After (159,119) is issued, go to SERVE and set clearing=0 at the same edge.
  - Exactly 19200 consecutive plot cycles. The first one is visible on outputs the cycle after the first non-reset edge.
  - grant=0 throughout CLEAR; requests are held off, not dropped.
- SERVE:
  - Priority order starts at rr pointer p: p, p+1, ..., wrapping mod N_REQ.
  - Lowest-ordered asserted req i gets grant[i]=1 in the same cycle (combinational).
  - At that edge: x/y/colour <= engine i fields, plot <= 1, p <= (i+1) mod N_REQ.
  - No req asserted: plot <= 0, p unchanged, x/y/colour hold.
- Latency: pixel appears on adapter outputs exactly 1 cycle after its grant.
- Throughput: 1 pixel per cycle. With all engines requesting, each engine gets 1 of every N_REQ grants; no engine waits more than N_REQ-1 cycles.
- Engine handshake:
  - An engine seeing grant[i] at an edge may present its next pixel or drop req in the next cycle.
  - Fields must be stable while req is high and grant is low.
- Out-of-range pixel (x>=160 or y>=120): still granted and consumed, but plot <= 0 for that cycle. Never wraps onto the screen.
- clear_start:
  - In SERVE: go to CLEAR, cx=cy=0, clearing=1. grant is forced 0 in the same cycle, so a pending request that cycle is not consumed.
  - In CLEAR: restart the sweep from (0,0).
- Reset mid-operation (CLEAR or SERVE): everything returns to reset values at the next edge, and any in-flight grant is void.
- idle: registered (state==SERVE && req==0); 0 during CLEAR.
- Arithmetic: rr pointer uses $clog2(N_REQ) bits with explicit wrap at N_REQ-1. cx is 8-bit, cy is 7-bit, compared against 159/119.

Decomposition:
- Shared package vga_pkg:
  - SCREEN_WIDTH=160, SCREEN_HEIGHT=120.
  - X_W=8, Y_W=7, COLOUR_W=3.
  - Colour constants BLACK/BLUE/GREEN/YELLOW/RED/WHITE.
  - typedef enum for state {CLEAR, SERVE}.
- One sub-module: rr_pick.
  - Inputs: N-bit req, pointer.
  - Outputs: one-hot grant, index, any.
  - Purely combinational.
- Top keeps the FSM, sweep counters and output registers.

Test Plan:
1. Reset 3 cycles, CLEAR_ON_RESET=1, no req -> plot high for exactly 19200 cycles; first pixel (0,0,000), pixel 161 = (0,1), last (159,119); then clearing=0, idle=1, plot=0.
2. In SERVE, only engine 2 requests (40,40,001) then (41,40,001) -> grant[2] on consecutive cycles; outputs show each pixel 1 cycle later with plot=1.
3. All 5 engines request continuously -> grant order 0,1,2,3,4,0,... starting from p=0; each engine granted every 5th cycle.
4. Engine 1 requests (160,10,100) -> grant[1]=1, next cycle plot=0; then (159,119,100) -> plot=1.
5. clear_start while engines 0 and 3 request -> no grant that cycle; 19200-cycle sweep; engine 0 (p unchanged) granted first afterward with its held pixel.
6. reset asserted at sweep pixel 500, then released -> sweep restarts at (0,0); full 19200 plots follow.
